// File: rtl/mem_arbiter.sv
// Round-robin single-owner memory arbiter: N_PROC processor ports share one memory port.
// Define ARB_TIMEOUT_EN to force release of a grant held for MAX_HOLD cycles.
module mem_arbiter #(
    parameter int N_PROC   = 4,
    parameter int ADDR_W   = 16,
    parameter int MAX_HOLD = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic [N_PROC-1:0]             i_req_rd,
    input  logic [N_PROC-1:0]             i_req_wr,
    input  logic [N_PROC-1:0][ADDR_W-1:0] i_addr,
    input  logic [N_PROC-1:0][2:0]        i_wr_size,
    input  logic [N_PROC-1:0][4:0][31:0]  i_wdata,
    output logic [N_PROC-1:0]             o_grant_rd,
    output logic [N_PROC-1:0]             o_grant_wr,
    output logic [ADDR_W-1:0]             o_mem_addr,
    output logic                          o_mem_we,
    output logic [2:0]                    o_mem_wr_size,
    output logic [4:0][31:0]              o_mem_wdata,
    output logic [$clog2(N_PROC)-1:0]     o_owner,
    output logic                          o_busy,
    output logic                          o_timeout
);
    localparam int OW = $clog2(N_PROC);
    localparam logic [N_PROC-1:0] ONE = N_PROC'(1);

    if (N_PROC < 2 || N_PROC > 8) begin : g_chk_n
        $error("mem_arbiter: N_PROC must be 2..8");
    end
    if (MAX_HOLD < 1) begin : g_chk_hold
        $error("mem_arbiter: MAX_HOLD must be >= 1");
    end

    typedef enum logic {IDLE, OWNED} state_t;

    state_t            state;
    logic [N_PROC-1:0] grant_rd, grant_wr;
    logic [OW-1:0]     owner, last_owner;
    logic              timeout;

    logic [N_PROC-1:0][2:0] size_sat;
    for (genvar p = 0; p < N_PROC; p++) begin : g_port
        assign size_sat[p] = (i_wr_size[p] > 3'd4) ? 3'd4 : i_wr_size[p];
    end

    logic              expire;
    logic [N_PROC-1:0] mask;
`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);
    logic [CW-1:0] hold_cnt;
    assign expire = (state == OWNED) && (hold_cnt == CW'(MAX_HOLD - 1));
    // An expiring owner sits out the re-arbitration at the release edge.
    assign mask   = expire ? (ONE << owner) : '0;
`else
    assign expire = 1'b0;
    assign mask   = '0;
`endif

    // Round-robin scan starting just after the last owner.
    logic [N_PROC-1:0] cand;
    logic              pick_vld;
    logic [OW-1:0]     pick, scan_idx;
    assign cand = (i_req_rd | i_req_wr) & ~mask;

    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        scan_idx = '0;
        for (int k = N_PROC; k >= 1; k--) begin
            scan_idx = OW'((int'(last_owner) + k) % N_PROC);
            if (cand[scan_idx]) begin
                pick_vld = 1'b1;
                pick     = scan_idx;
            end
        end
    end

    logic              hold_rd, hold_wr, owner_req, rearb;
    logic [N_PROC-1:0] pick_oh, own_oh;
    assign pick_oh   = ONE << pick;
    assign own_oh    = ONE << owner;
    assign hold_rd   = grant_rd[owner] & i_req_rd[owner];
    assign hold_wr   = grant_wr[owner] & i_req_wr[owner];
    assign owner_req = i_req_rd[owner] | i_req_wr[owner];
    assign rearb     = (state == IDLE) || !owner_req || expire;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state      <= IDLE;
            grant_rd   <= '0;
            grant_wr   <= '0;
            owner      <= '0;
            last_owner <= OW'(N_PROC - 1);
            timeout    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt   <= '0;
`endif
        end else begin
            timeout <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt + CW'(1);
`endif
            if (rearb) begin
                timeout <= expire;
`ifdef ARB_TIMEOUT_EN
                hold_cnt <= '0;
`endif
                if (pick_vld) begin
                    state      <= OWNED;
                    owner      <= pick;
                    last_owner <= pick;
                    grant_wr   <= i_req_wr[pick] ? pick_oh : '0;
                    grant_rd   <= i_req_wr[pick] ? '0 : pick_oh;
                end else begin
                    state    <= IDLE;
                    owner    <= '0;
                    grant_rd <= '0;
                    grant_wr <= '0;
                end
            end else if (!(hold_rd | hold_wr)) begin
                // Owner changed request type: keep ownership, flip grant kind.
                grant_wr <= i_req_wr[owner] ? own_oh : '0;
                grant_rd <= i_req_wr[owner] ? '0 : own_oh;
            end
        end
    end

    assign o_grant_rd    = grant_rd;
    assign o_grant_wr    = grant_wr;
    assign o_owner       = owner;
    assign o_busy        = (state == OWNED);
    assign o_timeout     = timeout;
    assign o_mem_we      = grant_wr[owner] & i_req_wr[owner];
    assign o_mem_addr    = o_busy ? i_addr[owner]   : '0;
    assign o_mem_wr_size = o_busy ? size_sat[owner] : 3'd0;
    assign o_mem_wdata   = o_busy ? i_wdata[owner]  : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected outputs, monitor compares.
module tb_mem_arbiter;
    logic                  clk, rstn;
    logic [3:0]            req_rd, req_wr;
    logic [3:0][15:0]      addr;
    logic [3:0][2:0]       wsz;
    logic [3:0][4:0][31:0] wdata;
    logic [3:0]            g_rd, g_wr;
    logic [15:0]           m_addr;
    logic                  m_we, busy, tmo;
    logic [2:0]            m_sz;
    logic [4:0][31:0]      m_wd;
    logic [1:0]            own;

    mem_arbiter #(.N_PROC(4), .ADDR_W(16), .MAX_HOLD(16)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_req_rd(req_rd), .i_req_wr(req_wr),
        .i_addr(addr), .i_wr_size(wsz), .i_wdata(wdata),
        .o_grant_rd(g_rd), .o_grant_wr(g_wr), .o_mem_addr(m_addr), .o_mem_we(m_we),
        .o_mem_wr_size(m_sz), .o_mem_wdata(m_wd), .o_owner(own), .o_busy(busy),
        .o_timeout(tmo)
    );

    typedef struct {
        string        nm;
        int           tag;
        logic [3:0]   grd, gwr;
        logic [1:0]   own;
        logic         busy, we, to;
        logic [15:0]  addr;
        logic [2:0]   sz;
        logic [159:0] wd;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0, n_chk = 0, n_pass = 0;
    logic stim_done = 1'b0;

    logic [15:0] addr_tab [4] = '{16'h0100, 16'h0101, 16'h0080, 16'h0103};
    logic [2:0]  sz_exp   [4] = '{3'd1, 3'd4, 3'd4, 3'd3};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [159:0] wd_exp(input int p);
        logic [159:0] r;
        for (int b = 0; b < 5; b++) r[b*32 +: 32] = 32'hD000_0000 + 32'(p * 256 + b);
        return r;
    endfunction

    // rmode: 0 hold reset low, 1 reset high, 2 short reset pulse between edges
    task automatic step(input string nm, input int rmode, input logic [3:0] rd, wr,
                        input logic [3:0] grd, gwr, input int o, input logic we, to);
        exp_t e;
        @(negedge clk);
        req_rd = rd;
        req_wr = wr;
        if (rmode == 2) begin
            rstn = 1'b0;
            #2;
            rstn = 1'b1;
        end else begin
            rstn = (rmode == 1);
        end
        e.nm   = nm;
        e.tag  = cyc + 1;
        e.grd  = grd;
        e.gwr  = gwr;
        e.busy = |(grd | gwr);
        e.own  = e.busy ? 2'(o) : 2'd0;
        e.we   = we;
        e.to   = to;
        e.addr = e.busy ? addr_tab[o] : 16'h0;
        e.sz   = e.busy ? sz_exp[o] : 3'd0;
        e.wd   = e.busy ? wd_exp(o) : 160'h0;
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        while (sb.size() > 0 && (sb[0].tag <= cyc || stim_done)) begin
            e = sb.pop_front();
            n_chk++;
            if (e.tag != cyc) begin
                $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.nm, cyc, e.tag);
            end else if ({g_rd, g_wr, own, busy, m_we, tmo, m_addr, m_sz, m_wd} !==
                         {e.grd, e.gwr, e.own, e.busy, e.we, e.to, e.addr, e.sz, e.wd}) begin
                $display("FAIL %s: got rd=%b wr=%b own=%0d busy=%b we=%b to=%b addr=%h sz=%0d wd=%h; want rd=%b wr=%b own=%0d busy=%b we=%b to=%b addr=%h sz=%0d wd=%h",
                         e.nm, g_rd, g_wr, own, busy, m_we, tmo, m_addr, m_sz, m_wd,
                         e.grd, e.gwr, e.own, e.busy, e.we, e.to, e.addr, e.sz, e.wd);
            end else begin
                n_pass++;
            end
        end
    end

    initial begin
        rstn   = 1'b0;
        req_rd = '0;
        req_wr = '0;
        wsz    = '{3'd3, 3'd4, 3'd7, 3'd1};
        for (int p = 0; p < 4; p++) begin
            addr[p] = addr_tab[p];
            for (int b = 0; b < 5; b++) wdata[p][b] = 32'hD000_0000 + 32'(p * 256 + b);
        end

        step("reset",     0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        step("idle",      1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        step("rd0",       1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0);
        step("rr0b",      1, 4'b1111, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0);
        step("rr1a",      1, 4'b1110, 4'b0000, 4'b0010, 4'b0000, 1, 0, 0);
        step("rr1b",      1, 4'b1110, 4'b0000, 4'b0010, 4'b0000, 1, 0, 0);
        step("rr2a",      1, 4'b1100, 4'b0000, 4'b0100, 4'b0000, 2, 0, 0);
        step("rr2b",      1, 4'b1100, 4'b0000, 4'b0100, 4'b0000, 2, 0, 0);
        step("rr3a",      1, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 3, 0, 0);
        step("rr3b",      1, 4'b1000, 4'b0000, 4'b1000, 4'b0000, 3, 0, 0);
        step("rr_idle",   1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        step("rd2",       1, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 2, 0, 0);
        step("rd2_to_wr", 1, 4'b1000, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0);
        step("wr2_hold",  1, 4'b1001, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0);
        step("rst_mid",   0, 4'b1001, 4'b0100, 4'b0000, 4'b0000, 0, 0, 0);
        step("post_rst",  1, 4'b1001, 4'b0100, 4'b0001, 4'b0000, 0, 0, 0);
        step("wr2_again", 1, 4'b1000, 4'b0100, 4'b0000, 4'b0100, 2, 1, 0);
        step("rst_pulse", 2, 4'b1001, 4'b0100, 4'b0001, 4'b0000, 0, 0, 0);
        step("idle2",     1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        step("rdwr1",     1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0);
        step("rdwr1_hold",1, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 1, 0);
        step("idle3",     1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);
        step("wr3",       1, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 3, 1, 0);
        step("idle4",     1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);

        step("hold0",     1, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++)
            step("hold0_n", 1, 4'b1001, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0);
        step("timeout",   1, 4'b1001, 4'b0000, 4'b1000, 4'b0000, 3, 0, 1);
        step("after_to",  1, 4'b1001, 4'b0000, 4'b1000, 4'b0000, 3, 0, 0);
`else
        for (int i = 0; i < 20; i++)
            step("hold0_n", 1, 4'b1001, 4'b0000, 4'b0001, 4'b0000, 0, 0, 0);
`endif
        step("idle5",     1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0);

        @(negedge clk);
        stim_done = 1'b1;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter N_PROC, default 4: number of processor ports (2..8).
REQ-002 SHALL have parameter ADDR_W, default 16: width of the address fields.
REQ-003 SHALL have parameter MAX_HOLD, default 16: grant hold limit in cycles; used only under ARB_TIMEOUT_EN.
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port i_rstn, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port i_req_rd, input, N_PROC bits: per-processor read request.
REQ-007 SHALL have port i_req_wr, input, N_PROC bits: per-processor write request.
REQ-008 SHALL have port i_addr, input, N_PROC x ADDR_W: per-processor address.
REQ-009 SHALL have port i_wr_size, input, N_PROC x 3: per-processor write block count, 0..4.
REQ-010 SHALL have port i_wdata, input, N_PROC x 5 x 32: per-processor write data.
REQ-011 SHALL have port o_grant_rd, output, N_PROC bits: read grant, one-hot or zero.
REQ-012 SHALL have port o_grant_wr, output, N_PROC bits: write grant, one-hot or zero.
REQ-013 SHALL have port o_mem_addr, output, ADDR_W: memory address.
REQ-014 SHALL have port o_mem_we, output, 1 bit: memory write strobe.
REQ-015 SHALL have port o_mem_wr_size, output, 3 bits: memory write block count.
REQ-016 SHALL have port o_mem_wdata, output, 5 x 32: memory write data.
REQ-017 SHALL have port o_owner, output, clog2(N_PROC) bits: index of the granted port.
REQ-018 SHALL have port o_busy, output, 1 bit: high while any grant is held.
REQ-019 SHALL have port o_timeout, output, 1 bit: one-cycle pulse on forced release.

Function
REQ-020 SHALL implement states IDLE and OWNED; grants are registered, so a request sampled at edge k yields a grant visible after edge k.
REQ-021 SHALL, in IDLE or on release, select the first port with i_req_rd|i_req_wr searching round-robin from last_owner+1 (mod N_PROC), then enter OWNED.
REQ-022 SHALL grant write only (o_grant_wr) when the winning port asserts both i_req_rd and i_req_wr.
REQ-023 SHALL hold the grant while the owner keeps its granted request type asserted; this is the case for a read grant spanning FETCH1 and FETCH2 of a processor.
REQ-024 SHALL, when the owner switches from read to write without deasserting all requests, move the owner from o_grant_rd to o_grant_wr at the next edge without re-arbitrating.
REQ-025 SHALL release the grant at the edge after the owner drops all requests and re-arbitrate at that same edge, so the next grant appears with zero idle cycles; if nobody is requesting, go to IDLE.
REQ-026 SHALL drive o_mem_addr, o_mem_wr_size and o_mem_wdata combinationally from the owner port while in OWNED, and zero in IDLE.
REQ-027 SHALL assert o_mem_we only when o_grant_wr[owner]=1 and i_req_wr[owner]=1.
REQ-028 SHALL saturate o_mem_wr_size at 4 when i_wr_size is greater than 4.
REQ-029 SHALL never assert more than one bit across o_grant_rd|o_grant_wr.
REQ-030 SHALL set o_busy high exactly when state is OWNED.

Reset
REQ-031 SHALL, on i_rstn=0 at any time including mid-grant, immediately clear all grants, o_mem_we, o_busy, o_timeout and o_owner, set state to IDLE and set last_owner to N_PROC-1 (port 0 is searched first).
REQ-032 SHALL make the first grant after reset deassertion no earlier than the first rising edge with i_rstn=1.

Configuration
REQ-033 SHALL, with ARB_TIMEOUT_EN defined, count owner cycles and, after MAX_HOLD consecutive cycles, force release, pulse o_timeout for one cycle and re-arbitrate excluding that owner for one round.
REQ-034 SHALL, without ARB_TIMEOUT_EN, hold grants indefinitely and tie o_timeout to 0.

Verification
REQ-035 SHALL cover: reset, then i_req_rd=0001 -> o_grant_rd=0001 after 1 edge, o_owner=0, o_busy=1.
REQ-036 SHALL cover: i_req_rd=1111 held, each owner drops its request after 2 cycles -> grant order 0,1,2,3, no gap cycles.
REQ-037 SHALL cover: owner 2 moves from rd to wr with i_wr_size=4, i_addr=0x0080 -> o_grant_wr=0100, o_mem_we=1, o_mem_addr=0x0080, o_mem_wr_size=4.
REQ-038 SHALL cover: port 1 asserts rd and wr together -> o_grant_wr=0010, o_grant_rd=0000.
REQ-039 SHALL cover: i_rstn pulsed low mid-write -> o_mem_we and grants 0 in the same cycle, state IDLE.
REQ-040 SHALL cover: with ARB_TIMEOUT_EN, MAX_HOLD=16, port 0 holds and port 3 requests -> o_timeout pulse at cycle 16, o_grant_rd=1000 next.
